// File: rtl/fixed_point_divider.sv
// Sequential signed fixed-point divider: restoring shift-subtract, one quotient bit per clock.
// Truncates toward zero; saturates on overflow and on divide-by-zero.
module fixed_point_divider #(
    parameter int WIDTH              = 16,
    parameter int EXP_WIDTH_A        = 5,
    parameter int EXP_WIDTH_B        = 15,
    parameter int EXP_WIDTH_QUOTIENT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam int SHIFT    = EXP_WIDTH_QUOTIENT - EXP_WIDTH_A + EXP_WIDTH_B;
    localparam int NUM_BITS = WIDTH + SHIFT;
    localparam int MAG_W    = WIDTH + 1;
    localparam int REM_W    = WIDTH + 2;
    localparam int CNT_W    = $clog2(NUM_BITS + 1);

    localparam logic [NUM_BITS-1:0] POS_LIM = {{(NUM_BITS-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [NUM_BITS-1:0] NEG_LIM = POS_LIM + NUM_BITS'(1);
    localparam logic [WIDTH-1:0]    MAX_Q   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]    MIN_Q   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t              state_q;
    logic [NUM_BITS-1:0] num_q;
    logic [NUM_BITS-1:0] qm_q;
    logic [MAG_W-1:0]    rem_q;
    logic [MAG_W-1:0]    mag_b_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                sign_q;
    logic                sign_a_q;
    logic                zero_q;
    logic                busy_q;
    logic                done_q;
    logic                ovf_q;
    logic                dbz_q;
    logic [WIDTH-1:0]    quot_q;

    logic [MAG_W-1:0]    a_ext;
    logic [MAG_W-1:0]    b_ext;
    logic [MAG_W-1:0]    mag_a_d;
    logic [MAG_W-1:0]    mag_b_d;
    logic [REM_W-1:0]    rem_shift;
    logic [REM_W-1:0]    diff;
    logic                qbit_d;
    logic [MAG_W-1:0]    rem_d;
    logic [WIDTH-1:0]    quot_d;
    logic                ovf_d;

    // Operands widened by one bit so that |-2^(WIDTH-1)| stays representable.
    always_comb begin
        a_ext   = {A[WIDTH-1], A};
        b_ext   = {B[WIDTH-1], B};
        mag_a_d = A[WIDTH-1] ? -a_ext : a_ext;
        mag_b_d = B[WIDTH-1] ? -b_ext : b_ext;
    end

    // Restoring step: the borrow (MSB of the difference) decides the quotient bit.
    always_comb begin
        rem_shift = {rem_q, num_q[NUM_BITS-1]};
        diff      = rem_shift - {1'b0, mag_b_q};
        qbit_d    = ~diff[REM_W-1];
        rem_d     = qbit_d ? diff[MAG_W-1:0] : rem_shift[MAG_W-1:0];
    end

    always_comb begin
        ovf_d  = 1'b0;
        quot_d = '0;
        if (zero_q) begin
            ovf_d  = 1'b1;
            quot_d = sign_a_q ? MIN_Q : MAX_Q;
        end else if (!sign_q && (qm_q > POS_LIM)) begin
            ovf_d  = 1'b1;
            quot_d = MAX_Q;
        end else if (sign_q && (qm_q > NEG_LIM)) begin
            ovf_d  = 1'b1;
            quot_d = MIN_Q;
        end else begin
            quot_d = sign_q ? -qm_q[WIDTH-1:0] : qm_q[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            num_q    <= '0;
            qm_q     <= '0;
            rem_q    <= '0;
            mag_b_q  <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            sign_a_q <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
            quot_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        sign_q   <= A[WIDTH-1] ^ B[WIDTH-1];
                        sign_a_q <= A[WIDTH-1];
                        zero_q   <= (B == '0);
                        mag_b_q  <= mag_b_d;
                        num_q    <= NUM_BITS'(mag_a_d) << SHIFT;
                        rem_q    <= '0;
                        qm_q     <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    num_q <= num_q << 1;
                    rem_q <= rem_d;
                    qm_q  <= {qm_q[NUM_BITS-2:0], qbit_d};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NUM_BITS - 1)) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    quot_q  <= quot_d;
                    ovf_q   <= ovf_d;
                    dbz_q   <= zero_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;

endmodule
